// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: majority sampling, glitch/break handling, FWFT output FIFO.
// Latency: frame pushed h+1 cycles into the last stop bit (h = Prescale/2), head visible next cycle.
// Backpressure: Data_Valid/Data_Ready on the FIFO head; a frame completing into a full FIFO is dropped and pulses overrun.

module uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_wr, do_rd;

  assign rd_vld = (count != '0);
  // head forced to zero while empty so the outputs read 0 out of reset
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
  assign wr_rdy = (count != FULL_CNT) || rd_rdy;
  assign do_wr  = wr_vld && wr_rdy;
  assign do_rd  = rd_vld && rd_rdy;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module uart_rx_cfg #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_WIDTH = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [3:0]                DATA_LEN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic                      Data_Ready,
  output logic                      Data_Valid,
  output logic [MAX_DATA_WIDTH-1:0] P_DATA,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      overrun,
  output logic                      break_det,
  output logic                      busy
);
  localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_WIDTH);
  localparam logic [3:0] MIN_LEN = 4'd5;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK} state_t;

  state_t state_q, state_nxt;
  logic rx_meta, rx_s, rx_s_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, prescale_q, half;
  logic [3:0] bit_q, len_q, len_cfg;
  logic par_en_q, par_typ_q, stop2_q;
  logic smp0_q, smp1_q, maj;
  logic [MAX_DATA_WIDTH-1:0] data_q;
  logic par_bit_q, par_err_q, stp_err_q;
  logic overrun_q, break_q;
  logic at_s0, at_s1, at_dec, at_end, last_data, brk_cond;
  logic start, push, brk;
  logic fifo_wr_rdy;

  assign half      = prescale_q >> 1;
  assign at_s0     = (cnt_q == half - 1'b1);
  assign at_s1     = (cnt_q == half);
  assign at_dec    = (cnt_q == half + 1'b1);
  assign at_end    = (cnt_q == prescale_q - 1'b1);
  assign maj       = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
  assign last_data = (bit_q == len_q - 1'b1);
  assign brk_cond  = (data_q == '0) && !(par_en_q && par_bit_q) && !maj;

  always_comb begin
    len_cfg = DATA_LEN;
    if (DATA_LEN > MAX_LEN)      len_cfg = MAX_LEN;
    else if (DATA_LEN < MIN_LEN) len_cfg = MIN_LEN;
  end

  always_comb begin
    state_nxt = state_q;
    start     = 1'b0;
    push      = 1'b0;
    brk       = 1'b0;
    case (state_q)
      S_IDLE: if (rx_s_d && !rx_s) begin
        state_nxt = S_START;
        start     = 1'b1;
      end
      S_START: begin
        if (at_dec && maj) state_nxt = S_IDLE;
        else if (at_end)   state_nxt = S_DATA;
      end
      S_DATA:   if (at_end && last_data) state_nxt = par_en_q ? S_PARITY : S_STOP1;
      S_PARITY: if (at_end) state_nxt = S_STOP1;
      S_STOP1: begin
        // Prescale=4 puts the decision on the last count, so the STOP2 hop may coincide with it
        if (at_dec && brk_cond) begin
          brk       = 1'b1;
          state_nxt = S_BREAK;
        end else if (at_dec && !stop2_q) begin
          push      = 1'b1;
          state_nxt = S_IDLE;
        end else if (at_end && stop2_q) begin
          state_nxt = S_STOP2;
        end
      end
      S_STOP2: if (at_dec) begin
        push      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_d     <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      prescale_q <= '0;
      len_q      <= MIN_LEN;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      smp0_q     <= 1'b1;
      smp1_q     <= 1'b1;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      rx_meta   <= RX_IN;
      rx_s      <= rx_meta;
      rx_s_d    <= rx_s;
      state_q   <= state_nxt;
      break_q   <= brk;
      overrun_q <= push && !fifo_wr_rdy;
      if (start) begin
        prescale_q <= Prescale;
        len_q      <= len_cfg;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        stop2_q    <= STOP2;
        cnt_q      <= {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
        bit_q      <= '0;
        data_q     <= '0;
        par_bit_q  <= 1'b0;
        par_err_q  <= 1'b0;
        stp_err_q  <= 1'b0;
      end else if (state_q == S_IDLE || state_q == S_BREAK) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= at_end ? '0 : cnt_q + 1'b1;
        if (at_s0) smp0_q <= rx_s;
        if (at_s1) smp1_q <= rx_s;
        if (at_dec) begin
          case (state_q)
            S_DATA:   data_q[bit_q] <= maj;
            S_PARITY: begin
              par_bit_q <= maj;
              par_err_q <= ((^data_q) ^ maj) != par_typ_q;
            end
            S_STOP1:  stp_err_q <= ~maj;
            default:  ;
          endcase
        end
        if (at_end && state_q == S_DATA) bit_q <= bit_q + 1'b1;
      end
    end
  end

  uart_rx_fifo #(
    .W     (MAX_DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .wr_vld (push),
    .wr_dat ({stp_err_q | ~maj, par_err_q, data_q}),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (Data_Valid),
    .rd_dat ({stp_err, par_err, P_DATA}),
    .rd_rdy (Data_Ready)
  );

  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;
  assign break_det = break_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frames built bit-by-bit from the framing rules, expected FIFO entries,
// latencies and break/overrun counts predicted by a queue model and checked with immediate assertions.
module tb_uart_rx_cfg;
  localparam int MDW   = 9;
  localparam int DEPTH = 4;

  logic           CLK = 1'b0;
  logic           RST, RX_IN, PAR_EN, PAR_TYP, STOP2, Data_Ready;
  logic [5:0]     Prescale;
  logic [3:0]     DATA_LEN;
  logic           Data_Valid, par_err, stp_err, overrun, break_det, busy;
  logic [MDW-1:0] P_DATA;

  typedef struct {
    logic [MDW-1:0] d;
    logic           pe;
    logic           se;
    int             fall;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, brk_cnt = 0, ovr_cnt = 0;

  uart_rx_cfg #(.MAX_DATA_WIDTH(MDW), .PRESCALE_WIDTH(6), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .DATA_LEN(DATA_LEN),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .Data_Ready(Data_Ready),
    .Data_Valid(Data_Valid), .P_DATA(P_DATA), .par_err(par_err), .stp_err(stp_err),
    .overrun(overrun), .break_det(break_det), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RST) begin
      if (break_det) brk_cnt++;
      if (overrun) ovr_cnt++;
      if (Data_Valid && Data_Ready) begin
        check("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("p_data", P_DATA, e.d);
          check("par_err", par_err, e.pe);
          check("stp_err", stp_err, e.se);
          if (e.lat != 0) check("latency", cyc - e.fall, e.lat);
        end
      end
    end
  end

  // Serialises one frame, records the expected entry, scrambles config once it should be latched.
  task automatic send_frame(input int p, input int len, input bit pe, input bit pt, input bit s2,
                            input logic [MDW-1:0] d, input bit bad_par, input bit st1, input bit st2,
                            input int gap, input bit keep, input bit chk_lat, output bit brk);
    int L, n;
    logic [MDW-1:0] dm;
    logic pb;
    logic bits[$];
    exp_t e;
    L  = (len > MDW) ? MDW : ((len < 5) ? 5 : len);
    dm = '0;
    for (int i = 0; i < L; i++) dm[i] = d[i];
    pb = (^dm) ^ pt ^ bad_par;
    bits.push_back(1'b0);
    for (int i = 0; i < L; i++) bits.push_back(dm[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(st1);
    if (s2) bits.push_back(st2);
    brk   = (dm == '0) && (!pe || !pb) && !st1;
    e.d   = dm;
    e.pe  = pe && bad_par;
    e.se  = !st1 || (s2 && !st2);
    e.lat = chk_lat ? (bits.size() - 1) * p + p / 2 + 4 : 0;
    @(posedge CLK); #1;
    Prescale = 6'(p); DATA_LEN = 4'(len); PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
    n = 0;
    foreach (bits[i]) begin
      RX_IN = bits[i];
      if (i == 0) begin
        e.fall = cyc;
        if (keep && !brk) exp_q.push_back(e);
      end
      repeat (p) begin
        @(posedge CLK); #1;
        n++;
        if (n == 3) begin
          Prescale = 6'($urandom_range(4, 63));
          DATA_LEN = 4'($urandom);
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
          STOP2    = 1'($urandom);
        end
      end
    end
    RX_IN = 1'b1;
    repeat (gap) @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge CLK);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit brk;
    int b0, o0;
    RST = 1'b0; RX_IN = 1'b1; Data_Ready = 1'b1;
    Prescale = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    #2 RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid", Data_Valid, 0);
    check("rst_pdata", P_DATA, 0);
    check("rst_par", par_err, 0);
    check("rst_stp", stp_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_brk", break_det, 0);
    check("rst_busy", busy, 0);
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    // basic frame with exact latency
    send_frame(8, 8, 0, 0, 0, 9'h0A5, 0, 1, 1, 6, 1, 1, brk);
    wait_drain("a5_drain");

    // wrong then correct odd parity, 7 data bits
    send_frame(8, 7, 1, 1, 0, 9'h055, 1, 1, 1, 6, 1, 1, brk);
    send_frame(8, 7, 1, 1, 0, 9'h055, 0, 1, 1, 6, 1, 1, brk);
    wait_drain("par_drain");

    // 9 bits, second stop bit low
    send_frame(8, 9, 0, 0, 1, 9'h1FF, 0, 1, 0, 6, 1, 1, brk);
    wait_drain("stop2_drain");

    // 3-cycle start glitch at Prescale=16
    Prescale = 6'd16; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    b0 = brk_cnt;
    @(posedge CLK); #1 RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("glitch_busy_pre", busy, 0);
    @(posedge CLK); #1 RX_IN = 1'b1;
    @(negedge CLK);
    check("glitch_busy_rise", busy, 1);
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    check("glitch_busy_fall", busy, 0);
    check("glitch_no_valid", Data_Valid, 0);
    check("glitch_no_break", brk_cnt - b0, 0);
    send_frame(16, 8, 0, 0, 0, 9'h03C, 0, 1, 1, 6, 1, 1, brk);
    wait_drain("glitch_drain");

    // randomized frames
    for (int k = 0; k < 40; k++) begin
      int p, len;
      bit pe, pt, s2, bp, s1b, s2b;
      logic [MDW-1:0] d;
      p   = $urandom_range(4, 20);
      len = $urandom_range(0, 15);
      pe  = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      s1b = ($urandom_range(0, 4) != 0);
      s2b = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 5) == 0) ? '0 : MDW'($urandom);
      b0  = brk_cnt;
      send_frame(p, len, pe, pt, s2, d, bp, s1b, s2b, $urandom_range(3, 10), 1, 1, brk);
      check("rand_break", brk_cnt - b0, brk);
    end
    wait_drain("rand_drain");

    // overrun: DEPTH+1 frames with consumer stalled
    Data_Ready = 1'b0;
    o0 = ovr_cnt;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      send_frame(8, 8, 0, 0, 0, MDW'(k), 0, 1, 1, 5, k <= DEPTH, 0, brk);
      if (k == DEPTH) check("ovr_before_full", ovr_cnt - o0, 0);
    end
    check("ovr_once", ovr_cnt - o0, 1);
    @(negedge CLK);
    check("ovr_valid", Data_Valid, 1);
    check("ovr_head", P_DATA, exp_q[0].d);
    Data_Ready = 1'b1;
    wait_drain("ovr_drain");

    // line held low for two frame times
    Prescale = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    b0 = brk_cnt;
    @(posedge CLK); #1 RX_IN = 1'b0;
    repeat (160) @(posedge CLK);
    @(negedge CLK);
    check("brk_pulse", brk_cnt - b0, 1);
    check("brk_busy", busy, 1);
    check("brk_no_valid", Data_Valid, 0);
    RX_IN = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("brk_exit", busy, 0);
    check("brk_single", brk_cnt - b0, 1);

    // reset in the middle of a frame with a held entry
    Data_Ready = 1'b0;
    send_frame(8, 9, 0, 0, 1, 9'h1AB, 0, 1, 0, 6, 1, 0, brk);
    @(negedge CLK);
    check("held_valid", Data_Valid, 1);
    check("held_pdata", P_DATA, exp_q[0].d);
    check("held_stp", stp_err, exp_q[0].se);
    @(posedge CLK); #1 RX_IN = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    check("mid_busy", busy, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("mrst_valid", Data_Valid, 0);
    check("mrst_pdata", P_DATA, 0);
    check("mrst_par", par_err, 0);
    check("mrst_stp", stp_err, 0);
    check("mrst_ovr", overrun, 0);
    check("mrst_brk", break_det, 0);
    check("mrst_busy", busy, 0);
    RX_IN = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    Data_Ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    send_frame(8, 8, 1, 0, 0, 9'h0C3, 0, 1, 1, 6, 1, 1, brk);
    wait_drain("recover_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Runtime-configurable UART receiver: next-generation serial input block for the low-power multi-clock system. It runs in the RX clock domain and adds:
- runtime data length (5..MAX_DATA_WIDTH),
- optional parity and 1 or 2 stop bits,
- 3-sample majority voting, start-glitch rejection and break detection,
- an output FIFO with valid/ready handshake and overrun reporting.

It replaces the fixed-width receiver feeding the system controller's command parser.

## Interface
- MAX_DATA_WIDTH, 9: widest supported data field; P_DATA width.
- PRESCALE_WIDTH, 6: width of Prescale.
- FIFO_DEPTH, 4: received-frame buffer entries; power of two, ≥2.
- CLK  in  1  RX oversampling clock.
- RST  in  1  reset; one clock, asynchronous, active-high.
- RX_IN  in  1  serial line, asynchronous, idle high.
- Prescale  in  PRESCALE_WIDTH  clocks per bit; legal ≥4.
- DATA_LEN  in  4  data bits per frame; legal 5..MAX_DATA_WIDTH; values above MAX clamp to MAX, below 5 clamp to 5.
- PAR_EN  in  1  parity bit present.
- PAR_TYP  in  1  0 even, 1 odd.
- STOP2  in  1  two stop bits.
- Data_Ready  in  1  consumer accepts head entry.
- Data_Valid  out  1  FIFO non-empty.
- P_DATA  out  MAX_DATA_WIDTH  head data, right-justified, unused MSBs 0.
- par_err  out  1  head entry parity error.
- stp_err  out  1  head entry stop-bit error.
- overrun  out  1  one-cycle pulse: completed frame dropped, FIFO full.
- break_det  out  1  one-cycle pulse: break received.
- busy  out  1  FSM not in IDLE.

## Operation
- RX_IN passes through a 2-flop synchronizer (rx_s). All logic uses rx_s.
- Config inputs latched on start detection; changes mid-frame ignored.
- Edge counter: 0..Prescale−1 per bit, then wraps and bit index increments.
- Majority samples at edge counts h−1, h, h+1, with h = floor(Prescale/2). The bit value is the majority of the three.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
  - IDLE → START: rx_s 1→0; edge counter cleared.
  - START: majority 1 → IDLE (glitch; no push, no flags). Majority 0 → DATA at bit boundary.
  - DATA: bits LSB first into shift register; after DATA_LEN bits → PARITY if PAR_EN, else STOP1.
  - PARITY: par_err = (XOR of data bits ^ parity bit) != PAR_TYP.
  - STOP1: majority 0 → stp_err.
    - If data, parity (if present) and stop1 are all 0: break. Pulse break_det, no push, go to BREAK.
    - Otherwise → STOP2 if STOP2, else push and return to IDLE immediately at the stop sample decision (no wait for bit end).
  - STOP2: majority 0 → stp_err; push; → IDLE.
  - BREAK: wait for rx_s = 1 → IDLE.
- Frames with errors are still pushed, with their flags.
- FIFO, first-word-fall-through:
  - entry = {stp_err, par_err, data}.
  - pop when Data_Valid && Data_Ready.
  - push accepted if not full, or if a pop occurs in the same cycle.
  - otherwise the frame is dropped and overrun pulses.
- Reset (including mid-frame): FSM to IDLE, FIFO emptied, synchronizer set to 1. All outputs 0: P_DATA, par_err, stp_err, Data_Valid, overrun, break_det, busy.

## Timing
- t0: first CLK edge at which rx_s reads 0 in IDLE. This is 2 cycles after RX_IN falls.
- Bit k (start = 0) occupies cycles t0+k·P .. t0+k·P+P−1; the majority decision is registered at t0+k·P+h+1.
- NBITS = 1 + DATA_LEN + PAR_EN + 1 + STOP2.
- Push at t0+(NBITS−1)·P+h+1; Data_Valid and the head outputs update the following cycle.
- busy rises the cycle after t0 and falls the cycle after push.
- Next start is detectable from the cycle the FSM is in IDLE.
- Pop: head outputs advance the cycle after the handshake. Data_Valid falls that cycle if the FIFO becomes empty.
- Push into an empty FIFO with Data_Ready held high: entry visible for exactly one cycle.
- overrun and break_det: registered, high exactly one cycle.

## Test plan
- Prescale=8, DATA_LEN=8, no parity, 1 stop, frame 0xA5, Data_Ready=1 → Data_Valid high 1 cycle, P_DATA=0x0A5, flags 0, at RX_IN fall + 80 cycles.
- DATA_LEN=7, PAR_EN=1, PAR_TYP=1, data 0x55, wrong parity bit, then a second correct frame → head 1: P_DATA=0x055, par_err=1. Head 2: par_err=0.
- DATA_LEN=9, STOP2=1, data 0x1FF, second stop bit 0 → P_DATA=0x1FF, stp_err=1, par_err=0.
- RX_IN low for 3 cycles in IDLE with Prescale=16 → no Data_Valid, busy returns 0, line re-armed. A following 0x3C frame is received correctly.
- Data_Ready=0, send FIFO_DEPTH+1 frames 0x01.. → first FIFO_DEPTH entries retained in order. overrun pulses once at the last push. Then draining gives 0x01..0x04.
- RX_IN low for 2 frame times → break_det pulses once, no FIFO entry, FSM stays in BREAK until RX_IN high. Assert RST mid-frame → all outputs 0 next edge.
